// File: rtl/pdm_uart_framer.sv
// pdm_uart_framer: buffers 16-bit samples and sends each one as 8N1 bytes (SYNC_BYTE, high, low).
// Define PDM_UART_FRAMER_CHECKSUM_EN to append a fourth byte, high ^ low.
module pdm_uart_framer #(
    parameter int         PERIOD    = 10,
    parameter int         DEPTH     = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        tx,
    output logic        busy,
    output logic        frame_done
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CLK_W = $clog2(PERIOD);
`ifdef PDM_UART_FRAMER_CHECKSUM_EN
    localparam logic [1:0] LAST_BYTE = 2'd3;
`else
    localparam logic [1:0] LAST_BYTE = 2'd2;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [15:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    state_t           state;
    state_t           state_nx;
    logic [CLK_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [1:0]       byte_idx;
    logic [15:0]      pkt;
    logic [7:0]       cur_byte;
    logic             bit_end;
    logic             tx_nx;
    logic             frame_done_nx;

    // Ready depends only on the registered count, so a pop in the same cycle cannot reopen a full FIFO.
    assign in_ready = !rst && (count != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && (count != '0);
    assign bit_end  = (clk_cnt == CLK_W'(PERIOD - 1));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (byte_idx)
            2'd0:    cur_byte = SYNC_BYTE;
            2'd1:    cur_byte = pkt[15:8];
`ifdef PDM_UART_FRAMER_CHECKSUM_EN
            2'd3:    cur_byte = pkt[15:8] ^ pkt[7:0];
`endif
            default: cur_byte = pkt[7:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        tx_nx         = 1'b1;
        frame_done_nx = 1'b0;
        case (state)
            IDLE: begin
                if (pop) state_nx = START;
            end
            START: begin
                tx_nx = 1'b0;
                if (bit_end) state_nx = DATA;
            end
            DATA: begin
                tx_nx = cur_byte[bit_idx];
                if (bit_end && (bit_idx == 3'd7)) state_nx = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx == LAST_BYTE) begin
                        state_nx      = IDLE;
                        frame_done_nx = 1'b1;
                    end else begin
                        state_nx = START;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Line outputs are registered one clock behind the sequencer so tx never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_cnt    <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            pkt        <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tx         <= tx_nx;
            busy       <= (state != IDLE);
            frame_done <= frame_done_nx;
            if (state == IDLE) begin
                clk_cnt  <= '0;
                bit_idx  <= '0;
                byte_idx <= '0;
                if (pop) pkt <= mem[rd_ptr];
            end else if (bit_end) begin
                clk_cnt <= '0;
                if (state == DATA) bit_idx  <= bit_idx + 1'b1;
                if (state == STOP) byte_idx <= byte_idx + 1'b1;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pdm_uart_framer.sv
// Bench for pdm_uart_framer: decodes the tx line and compares each packet against words seen accepted.
// Honours PDM_UART_FRAMER_CHECKSUM_EN for the expected packet length.
module tb_pdm_uart_framer;
    localparam int P = 4;
    localparam int D = 4;
`ifdef PDM_UART_FRAMER_CHECKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        tx;
    logic        busy;
    logic        frame_done;

    pdm_uart_framer #(.PERIOD(P), .DEPTH(D), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] exp_q[$];
    int          acc_q[$];
    int          last_fd = -1000;
    int          fd_count = 0;
    int          pkts_done = 0;
    int          acc_total = 0;
    bit          mon_active = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [15:0] w, input int b);
        case (b)
            0:       return 8'hA5;
            1:       return w[15:8];
            2:       return w[7:0];
            default: return w[15:8] ^ w[7:0];
        endcase
    endfunction

    // Accepted words: a push happens on the posedge after a negedge that sees valid & ready.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(in_data);
            acc_q.push_back(cyc + 1);
            acc_total++;
        end
        if (!rst && frame_done) fd_count++;
    end

    task automatic decode_packet();
        logic [15:0] w;
        int          a;
        int          s;
        int          exp_s;
        logic [9:0]  bits;
        logic        stable;
        logic        busy_ok;
        logic        fd_ok;
        bit          first = 1'b1;
        mon_active = 1'b1;
        s = cyc;
        bits = '0;
        if (exp_q.size() == 0) begin
            check("unexpected_packet", exp_q.size(), 1);
            w = '0;
            a = s - 2;
        end else begin
            w = exp_q.pop_front();
            a = acc_q.pop_front();
        end
        // A packet starts two clocks after its accept, or two clocks after the previous frame_done.
        exp_s = (a > last_fd) ? a + 2 : last_fd + 2;
        check("start_cycle", s, exp_s);
        busy_ok = 1'b1;
        fd_ok   = 1'b1;
        for (int b = 0; b < NB; b++) begin
            stable = 1'b1;
            for (int i = 0; i < 10; i++) begin
                for (int c = 0; c < P; c++) begin
                    if (!first) @(negedge clk);
                    first = 1'b0;
                    if (rst) begin
                        mon_active = 1'b0;
                        return;
                    end
                    if (c == 0) bits[i] = tx;
                    else if (tx !== bits[i]) stable = 1'b0;
                    if (busy !== 1'b1) busy_ok = 1'b0;
                    if (frame_done !== ((b == NB - 1) && (i == 9) && (c == P - 1))) fd_ok = 1'b0;
                end
            end
            check("bit_stable", stable, 1);
            check("start_bit", bits[0], 0);
            check("stop_bit", bits[9], 1);
            check("byte_value", bits[8:1], exp_byte(w, b));
        end
        check("busy_in_packet", busy_ok, 1);
        check("frame_done_position", fd_ok, 1);
        last_fd = cyc;
        pkts_done++;
        @(negedge clk);
        if (!rst) begin
            check("busy_after_frame", busy, 0);
            check("line_high_after_frame", tx, 1);
        end
        mon_active = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) decode_packet();
        end
    end

    // Must be called one delta past a posedge; returns one delta past the accepting posedge, valid still high.
    task automatic push_word(input logic [15:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", n < 2000, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy || mon_active) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, n < 3000, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic idle_window(input int cycles, input string tag);
        logic ok = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) ok = 1'b0;
        end
        check(tag, ok, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached before the test sequence ended");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int fd0;
        int acc0;
        int n;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1);

        idle_window(1000, "idle_line");

        // Single word
        fd0 = fd_count;
        @(posedge clk); #1;
        push_word(16'h1234);
        in_valid = 1'b0;
        wait_drain("drain_single");
        check("single_frame_done_once", fd_count - fd0, 1);

        // Bit order and timing
        @(posedge clk); #1;
        push_word(16'h80FF);
        in_valid = 1'b0;
        wait_drain("drain_bit_order");

        // Backpressure and full-with-pop
        acc0 = acc_total;
        @(posedge clk); #1;
        fork
            begin
                for (int k = 1; k <= 6; k++) push_word(16'(k));
            end
            begin
                n = 0;
                @(negedge clk);
                while (in_ready && n < 1000) begin
                    @(negedge clk);
                    n++;
                end
                check("accepted_before_full", acc_total - acc0, 5);
                n = 0;
                while (!frame_done && n < 1000) begin
                    @(negedge clk);
                    n++;
                end
                check("full_pop_ready_low", in_ready, 0);
                @(negedge clk);
                check("full_pop_ready_rise", in_ready, 1);
                @(negedge clk);
                check("full_refill", in_ready, 0);
            end
        join
        in_valid = 1'b0;
        wait_drain("drain_backpressure");

        // Reset during the data bits of the low byte (all zeros, so the line is low there)
        @(posedge clk); #1;
        push_word(16'hBE00);
        push_word(16'h1111);
        in_valid = 1'b0;
        n = 0;
        while (!busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("busy_rise", busy, 1);
        repeat (21 * P + 5) @(negedge clk);
        check("tx_before_reset", tx, 0);
        #2;
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        last_fd = -1000;
        #1;
        check("midreset_tx", tx, 1);
        check("midreset_busy", busy, 0);
        check("midreset_frame_done", frame_done, 0);
        check("midreset_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_window(200, "no_resume_after_reset");
        @(posedge clk); #1;
        push_word(16'h4321);
        in_valid = 1'b0;
        wait_drain("drain_after_reset");

        // Randomized words with random idle gaps
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            push_word(16'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 160)) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        wait_drain("drain_random");

        check("frame_done_per_packet", fd_count, pkts_done);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
